// File: rtl/mant_mul_seq_ctrl.sv
// Radix-2 shift-and-add significand multiplier that time-shares one external
// W-bit adder, retiring one partial product per clock.
module mant_mul_seq_ctrl #(
  parameter int W  = 22,
  parameter int CW = $clog2(W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  output logic           ready,
  output logic           done,
  output logic [2*W-1:0] product,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  output logic [1:0]     add_kin,
  input  logic [W:0]     add_sum
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] product_q, product_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    ready     = 1'b0;
    done      = 1'b0;
    add_a     = '0;
    add_b     = '0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          if ((a_in != '0) && (b_in != '0)) begin
            mcand_d = a_in;
            lo_d    = b_in;
            hi_d    = '0;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            // A zero operand short-circuits straight to a zero product.
            product_d = '0;
            state_d   = DONE;
          end
        end
      end
      RUN: begin
        add_a = hi_q;
        add_b = lo_q[0] ? mcand_q : '0;
        // The adder carry lands in hi's MSB; the bit shifted out of hi enters lo.
        hi_d  = add_sum[W:1];
        lo_d  = {add_sum[0], lo_q[W-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          product_d = {add_sum, lo_q[W-1:1]};
          state_d   = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign add_kin = 2'b00;
  assign product = product_q;

endmodule

// File: tb/tb_mant_mul_seq_ctrl.sv
// Directed self-checking bench for mant_mul_seq_ctrl; the shared adder is
// modelled here as a plain unsigned W+1-bit sum of add_a and add_b.
module tb_mant_mul_seq_ctrl;

  localparam int W = 22;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a_in, b_in;
  logic           ready, done;
  logic [2*W-1:0] product;
  logic [W-1:0]   add_a, add_b;
  logic [1:0]     add_kin;
  logic [W:0]     add_sum;

  int tests_run    = 0;
  int tests_failed = 0;

  mant_mul_seq_ctrl #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .ready   (ready),
    .done    (done),
    .product (product),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_kin (add_kin),
    .add_sum (add_sum)
  );

  assign add_sum = {1'b0, add_a} + {1'b0, add_b};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one start pulse and counts cycles after the accept edge until done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int cyc, output bit rdy_seen);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    step();
    start    = 1'b0;
    a_in     = '0;
    b_in     = '0;
    cyc      = 1;
    rdy_seen = 1'b0;
    while (1) begin
      if (ready) rdy_seen = 1'b1;
      if (done) break;
      if (cyc >= 60) begin
        cyc = -1;
        break;
      end
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: got %0b want 1", ready);
    end
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_done: got %0b want 0", done);
    end
    tests_run++;
    if (product !== '0) begin
      tests_failed++;
      $display("FAIL reset_product: got %h want 0", product);
    end
    tests_run++;
    if ((add_a !== '0) || (add_b !== '0) || (add_kin !== 2'b00)) begin
      tests_failed++;
      $display("FAIL reset_adder: got a=%h b=%h kin=%b want 0 0 00", add_a, add_b, add_kin);
    end
  endtask

  task automatic test_basic();
    int cyc;
    bit rdy_seen;
    start = 1'b1;
    a_in  = 22'd3;
    b_in  = 22'd5;
    step();
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    // First RUN cycle: hi=0, lo[0]=1 so the adder sees 0 + mcand.
    tests_run++;
    if ((add_a !== 22'd0) || (add_b !== 22'd3) || (add_kin !== 2'b00)) begin
      tests_failed++;
      $display("FAIL basic_adder_in: got a=%h b=%h kin=%b want 0 3 00", add_a, add_b, add_kin);
    end
    cyc      = 1;
    rdy_seen = 1'b0;
    while (1) begin
      if (ready) rdy_seen = 1'b1;
      if (done) break;
      if (cyc >= 60) begin
        cyc = -1;
        break;
      end
      step();
      cyc++;
    end
    tests_run++;
    if (cyc !== 23) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d want 23", cyc);
    end
    tests_run++;
    if (rdy_seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_ready_low: got ready high while busy want low");
    end
    tests_run++;
    if (product !== 44'd15) begin
      tests_failed++;
      $display("FAIL basic_product: got %h want %h", product, 44'd15);
    end
    step();
    tests_run++;
    if ((done !== 1'b0) || (ready !== 1'b1) || (product !== 44'd15)) begin
      tests_failed++;
      $display("FAIL basic_after_done: got done=%0b ready=%0b prod=%h want 0 1 f", done, ready, product);
    end
  endtask

  task automatic test_max();
    int cyc;
    bit rdy_seen;
    run_op(22'h3FFFFF, 22'h3FFFFF, cyc, rdy_seen);
    tests_run++;
    if (cyc !== 23) begin
      tests_failed++;
      $display("FAIL max_latency: got %0d want 23", cyc);
    end
    tests_run++;
    if (product !== 44'hFFFFF800001) begin
      tests_failed++;
      $display("FAIL max_product: got %h want %h", product, 44'hFFFFF800001);
    end
    step();
  endtask

  task automatic test_zero();
    start = 1'b1;
    a_in  = 22'd0;
    b_in  = 22'h2ABCDE;
    step();
    start = 1'b0;
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_latency: got done=%0b one cycle after accept want 1", done);
    end
    tests_run++;
    if (product !== '0) begin
      tests_failed++;
      $display("FAIL zero_product: got %h want 0", product);
    end
    tests_run++;
    if ((add_a !== '0) || (add_b !== '0)) begin
      tests_failed++;
      $display("FAIL zero_adder_idle: got a=%h b=%h want 0 0", add_a, add_b);
    end
    step();
    tests_run++;
    if ((done !== 1'b0) || (ready !== 1'b1)) begin
      tests_failed++;
      $display("FAIL zero_after_done: got done=%0b ready=%0b want 0 1", done, ready);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    start = 1'b1;
    a_in  = 22'd7;
    b_in  = 22'd9;
    step();
    a_in = 22'd2;
    b_in = 22'd2;
    cyc  = 1;
    while (!done && cyc < 60) begin
      step();
      cyc++;
    end
    tests_run++;
    if ((cyc !== 23) || (product !== 44'd63)) begin
      tests_failed++;
      $display("FAIL b2b_first: got cyc=%0d prod=%h want 23 %h", cyc, product, 44'd63);
    end
    step();
    tests_run++;
    if ((ready !== 1'b1) || (done !== 1'b0)) begin
      tests_failed++;
      $display("FAIL b2b_reaccept_idle: got ready=%0b done=%0b want 1 0", ready, done);
    end
    step();
    tests_run++;
    if ((ready !== 1'b0) || (product !== 44'd63)) begin
      tests_failed++;
      $display("FAIL b2b_second_run: got ready=%0b prod=%h want 0 %h", ready, product, 44'd63);
    end
    cyc = 1;
    while (!done && cyc < 60) begin
      step();
      cyc++;
    end
    start = 1'b0;
    tests_run++;
    if ((cyc !== 23) || (product !== 44'd4)) begin
      tests_failed++;
      $display("FAIL b2b_second: got cyc=%0d prod=%h want 23 %h", cyc, product, 44'd4);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int cyc;
    int done_cnt;
    bit rdy_seen;
    start = 1'b1;
    a_in  = 22'h123456;
    b_in  = 22'h0F0F0F;
    step();
    start = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    #1;
    tests_run++;
    if ((ready !== 1'b1) || (done !== 1'b0) || (product !== '0)) begin
      tests_failed++;
      $display("FAIL midreset_state: got ready=%0b done=%0b prod=%h want 1 0 0", ready, done, product);
    end
    tests_run++;
    if ((add_a !== '0) || (add_b !== '0)) begin
      tests_failed++;
      $display("FAIL midreset_adder: got a=%h b=%h want 0 0", add_a, add_b);
    end
    step();
    rst      = 1'b0;
    done_cnt = 0;
    repeat (30) begin
      step();
      if (done) done_cnt++;
    end
    tests_run++;
    if (done_cnt !== 0) begin
      tests_failed++;
      $display("FAIL midreset_no_done: got %0d done pulses want 0", done_cnt);
    end
    run_op(22'h123456, 22'h0F0F0F, cyc, rdy_seen);
    tests_run++;
    if ((cyc !== 23) || (rdy_seen !== 1'b0)) begin
      tests_failed++;
      $display("FAIL midreset_rerun_latency: got cyc=%0d ready_seen=%0b want 23 0", cyc, rdy_seen);
    end
    tests_run++;
    if (product !== 44'h112232C1B0A) begin
      tests_failed++;
      $display("FAIL midreset_rerun_product: got %h want %h", product, 44'h112232C1B0A);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
